// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer / bit stuffer.
package usb_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_STUFF_LIMIT  = 6;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts clocks while enabled and strobes on the last clock of each period.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en_i,
  input  logic clr_i,
  output logic new_bit_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST_COUNT) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign new_bit_o = en_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// USB transmit serializer: shifts packet bytes out LSB-first, inserts stuffed zeros
// after long runs of ones, and sequences the SE0/J end-of-packet to the NRZI encoder.
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_byte_i,
  input  logic       byte_valid_i,
  input  logic       last_byte_i,
  output logic       byte_ready_o,
  output logic       stuff_out_o,
  output logic       new_bit_o,
  output logic       idle_o,
  output logic       eop_o,
  output logic       tx_error_o,
  output logic       busy_o
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int EW = $clog2(2 * CLKS_PER_BIT);
  localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] SE0_LAST  = EW'(2 * CLKS_PER_BIT - 1);
  localparam logic [EW-1:0] J_LAST    = EW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_DONE = 4'd8;

  tx_state_t     state_q, state_d;
  logic [7:0]    shiftReg_q, shiftReg_d;
  logic          last_q, last_d;
  logic [7:0]    hold_q, hold_d;
  logic          holdLast_q, holdLast_d;
  logic          holdFull_q, holdFull_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [3:0]    bitIdx_q, bitIdx_d;
  logic [EW-1:0] eopCnt_q, eopCnt_d;

  logic          timerEn;
  logic          accept;
  logic [OW-1:0] onesNext;
  logic [3:0]    idxNext;
  logic          stuffNow;
  logic          byteDone;

  assign timerEn = (state_q == SHIFT) || (state_q == STUFF);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .en_i     (timerEn),
    .clr_i    (!timerEn),
    .new_bit_o(new_bit_o)
  );

  always_comb begin
    unique case (state_q)
      IDLE:         byte_ready_o = 1'b1;
      SHIFT, STUFF: byte_ready_o = !holdFull_q;
      default:      byte_ready_o = 1'b0;
    endcase
  end

  assign stuff_out_o = (state_q == SHIFT) ? shiftReg_q[0] : (state_q != STUFF);
  assign idle_o      = (state_q == IDLE) || (state_q == EOP_J);
  assign eop_o       = (state_q == EOP_SE0);
  assign busy_o      = (state_q != IDLE);
  assign accept      = byte_valid_i && byte_ready_o;

  // A byte is finished on the period that sends bit 7, unless a stuff bit must follow it,
  // in which case the boundary moves to the end of that stuff period.
  assign onesNext = shiftReg_q[0] ? ones_q + OW'(1) : '0;
  assign idxNext  = bitIdx_q + 4'd1;
  assign stuffNow = (onesNext == ONES_MAX);
  assign byteDone = new_bit_o &&
                    (((state_q == SHIFT) && !stuffNow && (idxNext == BYTE_DONE)) ||
                     ((state_q == STUFF) && (bitIdx_q == BYTE_DONE)));
  assign tx_error_o = byteDone && !last_q && !holdFull_q;

  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    last_d     = last_q;
    hold_d     = hold_q;
    holdLast_d = holdLast_q;
    holdFull_d = holdFull_q;
    ones_d     = ones_q;
    bitIdx_d   = bitIdx_q;
    eopCnt_d   = eopCnt_q;

    unique case (state_q)
      IDLE: begin
        eopCnt_d = '0;
        if (accept) begin
          shiftReg_d = tx_byte_i;
          last_d     = last_byte_i;
          ones_d     = '0;
          bitIdx_d   = '0;
          holdFull_d = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT, STUFF: begin
        if (accept) begin
          hold_d     = tx_byte_i;
          holdLast_d = last_byte_i;
          holdFull_d = 1'b1;
        end
        if (new_bit_o) begin
          if (state_q == SHIFT) begin
            ones_d     = onesNext;
            shiftReg_d = {1'b0, shiftReg_q[7:1]};
            bitIdx_d   = idxNext;
            if (stuffNow) begin
              state_d = STUFF;
            end
          end else begin
            ones_d = '0;
            if (bitIdx_q != BYTE_DONE) begin
              state_d = SHIFT;
            end
          end
          if (byteDone) begin
            if (last_q || !holdFull_q) begin
              state_d = EOP_SE0;
            end else begin
              shiftReg_d = hold_q;
              last_d     = holdLast_q;
              holdFull_d = 1'b0;
              bitIdx_d   = '0;
              state_d    = SHIFT;
            end
          end
          if (state_d == EOP_SE0) begin
            holdFull_d = 1'b0;
            eopCnt_d   = '0;
          end
        end
      end

      EOP_SE0: begin
        eopCnt_d = eopCnt_q + EW'(1);
        if (eopCnt_q == SE0_LAST) begin
          eopCnt_d = '0;
          state_d  = EOP_J;
        end
      end

      EOP_J: begin
        eopCnt_d = eopCnt_q + EW'(1);
        if (eopCnt_q == J_LAST) begin
          eopCnt_d = '0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      last_q     <= 1'b0;
      hold_q     <= '0;
      holdLast_q <= 1'b0;
      holdFull_q <= 1'b0;
      ones_q     <= '0;
      bitIdx_q   <= '0;
      eopCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      holdLast_q <= holdLast_d;
      holdFull_q <= holdFull_d;
      ones_q     <= ones_d;
      bitIdx_q   <= bitIdx_d;
      eopCnt_q   <= eopCnt_d;
    end
  end

endmodule
